// File: rtl/aes_trace_sequencer.sv
// AES trace sequencer: runs N_TRACES encryptions on an AES core
// and captures the first ciphertext strobe of every trace.
module aes_trace_sequencer #(
  parameter int DATA_W     = 128,
  parameter int N_TRACES   = 16,
  parameter int EN_CYCLES  = 51,
  parameter int GAP_CYCLES = 15,
  parameter int TIMEOUT    = 256,
  parameter int MODE       = 1
) (
  input  logic              AES_clk,
  input  logic              AES_rst_n,
  input  logic              seq_start,
  input  logic              seq_abort,
  input  logic [DATA_W-1:0] seq_key,
  input  logic [DATA_W-1:0] seq_seed,
  output logic              AES_en,
  output logic [DATA_W-1:0] AES_data_in,
  output logic [DATA_W-1:0] AES_key_in,
  input  logic [DATA_W-1:0] AES_data_out,
  input  logic              AES_data_out_valid,
  output logic              seq_busy,
  output logic              seq_done,
  output logic [15:0]       trace_idx,
  output logic [DATA_W-1:0] cap_data,
  output logic              cap_valid,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN, WAIT, GAP, DONE
  } state_t;

  localparam logic [31:0] EN_LAST  = 32'(EN_CYCLES - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);
  localparam logic [15:0] IDX_LAST = 16'(N_TRACES - 1);

  state_t            state, state_d;
  logic [31:0]       cnt, cnt_d;
  logic [DATA_W-1:0] key_r, seed_r, lfsr, pt;
  logic [DATA_W-1:0] pt_sel, seed_fix, lfsr_nxt;
  logic              captured, capture, tmo;
  logic              use_lfsr, last_trace;
  logic              starting, busy_d;

  function automatic logic [DATA_W-1:0] lfsr_step(
    input logic [DATA_W-1:0] c
  );
    return {c[DATA_W-2:0], c[DATA_W-1] ^ c[6] ^ c[1] ^ c[0]};
  endfunction

  always_comb begin
    // an all-zero seed would lock the LFSR
    seed_fix = seq_seed;
    if (MODE != 0 && seq_seed == '0)
      seed_fix = {{(DATA_W-1){1'b0}}, 1'b1};
  end

  always_comb begin
    use_lfsr = 1'b0;
    unique case (1'b1)
      (MODE == 1): use_lfsr = 1'b1;
      (MODE == 2): use_lfsr = trace_idx[0];
      default:     use_lfsr = 1'b0;
    endcase
    lfsr_nxt = lfsr_step(lfsr);
    pt_sel   = use_lfsr ? lfsr_nxt : seed_r;
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt + 32'd1;
    last_trace = (trace_idx >= IDX_LAST);
    capture    = AES_data_out_valid && !captured && !seq_abort
              && (state == RUN || state == WAIT);
    tmo        = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (seq_start && !seq_abort) state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (cnt == EN_LAST) begin
          cnt_d   = '0;
          state_d = (captured || capture) ? GAP : WAIT;
        end
      end
      WAIT: begin
        if (capture) begin
          cnt_d   = '0;
          state_d = GAP;
        end else if (cnt == TO_LAST) begin
          cnt_d   = '0;
          tmo     = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_d   = '0;
          state_d = last_trace ? DONE : LOAD;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    if (seq_abort && state != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      tmo     = 1'b0;
    end
    starting = (state == IDLE) && (state_d == LOAD);
    busy_d   = (state_d == LOAD) || (state_d == RUN)
            || (state_d == WAIT) || (state_d == GAP);
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      key_r       <= '0;
      seed_r      <= '0;
      lfsr        <= '0;
      pt          <= '0;
      captured    <= 1'b0;
      AES_en      <= 1'b0;
      AES_data_in <= '0;
      AES_key_in  <= '0;
      seq_busy    <= 1'b0;
      seq_done    <= 1'b0;
      trace_idx   <= '0;
      cap_data    <= '0;
      cap_valid   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      AES_en    <= (state_d == RUN);
      seq_busy  <= busy_d;
      seq_done  <= (state_d == DONE);
      cap_valid <= capture;
      if (capture) begin
        cap_data <= AES_data_out;
        captured <= 1'b1;
      end
      if (starting) begin
        key_r       <= seq_key;
        seed_r      <= seed_fix;
        lfsr        <= seed_fix;
        trace_idx   <= '0;
        timeout_err <= 1'b0;
      end
      if (state == LOAD) begin
        captured    <= 1'b0;
        pt          <= pt_sel;
        AES_data_in <= pt_sel;
        AES_key_in  <= key_r;
        if (use_lfsr) lfsr <= pt_sel;
      end
      // inverted plaintext keeps the bus switching between traces
      if (state_d == GAP && state != GAP)
        AES_data_in <= ~pt;
      if (tmo) timeout_err <= 1'b1;
      if (state == GAP && state_d == LOAD && trace_idx != 16'hFFFF)
        trace_idx <= trace_idx + 16'd1;
    end
  end

endmodule

// File: tb/tb_aes_trace_sequencer.sv
// Directed bench for aes_trace_sequencer: four parameter variants
// share one clock; a core model feeds a capture scoreboard.
`timescale 1ns/1ps
module tb_aes_trace_sequencer;
  localparam int W  = 128;
  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [W-1:0] key, seed;
  logic         start [NI];
  logic         abort [NI];
  logic         en [NI];
  logic         busy [NI];
  logic         done [NI];
  logic         capv [NI];
  logic         terr [NI];
  logic         mvalid [NI];
  logic         man_valid [NI];
  logic         valid [NI];
  logic         core_on [NI];
  logic [W-1:0] din [NI];
  logic [W-1:0] kin [NI];
  logic [W-1:0] dout [NI];
  logic [W-1:0] capd [NI];
  logic [15:0]  tidx [NI];

  int run_len [NI];
  int low_len [NI];
  int run_n [NI];
  int pt_n [NI];
  int cap_n [NI];
  int done_n [NI];
  int done_at [NI];
  int en_runs [NI][8];
  int gap_log [NI][8];
  logic [W-1:0] pt_log [NI][8];
  logic [W-1:0] gap_din [NI];
  int ncyc = 0;

  typedef struct {
    int           g;
    logic [W-1:0] d;
  } sb_t;
  sb_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < NI; g++) begin : gi
    assign valid[g] = mvalid[g] | man_valid[g];
    aes_trace_sequencer #(
      .DATA_W(W),
      .N_TRACES(g == 2 ? 4 : 2),
      .EN_CYCLES(51),
      .GAP_CYCLES(15),
      .TIMEOUT(g == 3 ? 4 : 256),
      .MODE(g == 3 ? 0 : g)
    ) u_dut (
      .AES_clk(clk),
      .AES_rst_n(rst_n),
      .seq_start(start[g]),
      .seq_abort(abort[g]),
      .seq_key(key),
      .seq_seed(seed),
      .AES_en(en[g]),
      .AES_data_in(din[g]),
      .AES_key_in(kin[g]),
      .AES_data_out(dout[g]),
      .AES_data_out_valid(valid[g]),
      .seq_busy(busy[g]),
      .seq_done(done[g]),
      .trace_idx(tidx[g]),
      .cap_data(capd[g]),
      .cap_valid(capv[g]),
      .timeout_err(terr[g])
    );
  end

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // monitor, core model and scoreboard
  always @(negedge clk) begin
    sb_t e;
    ncyc++;
    for (int g = 0; g < NI; g++) begin
      if (capv[g] === 1'b1) begin
        cap_n[g]++;
        if (sb.size() == 0) begin
          chk("cap_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("cap_inst", e.g, g);
          chk("cap_data", capd[g], e.d);
        end
      end
      if (done[g] === 1'b1) begin
        done_n[g]++;
        done_at[g] = ncyc;
      end
      if (en[g] === 1'b1) begin
        run_len[g]++;
        if (run_len[g] == 1) begin
          if (pt_n[g] < 8) pt_log[g][pt_n[g]] = din[g];
          pt_n[g]++;
          if (run_n[g] > 0 && run_n[g] <= 8)
            gap_log[g][run_n[g]-1] = low_len[g];
        end
        low_len[g] = 0;
      end else begin
        if (run_len[g] > 0) begin
          if (run_n[g] < 8) en_runs[g][run_n[g]] = run_len[g];
          run_n[g]++;
          gap_din[g] = din[g];
        end
        run_len[g] = 0;
        low_len[g]++;
      end
      mvalid[g] = 1'b0;
      if (core_on[g] && en[g] === 1'b1 && run_len[g] == 40) begin
        mvalid[g] = 1'b1;
        dout[g]   = din[g] ^ kin[g];
        sb.push_back('{g, din[g] ^ kin[g]});
      end
      if (core_on[g] && en[g] === 1'b1 && run_len[g] == 45) begin
        mvalid[g] = 1'b1;
        dout[g]   = ~din[g];
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr(input int g);
    run_n[g]  = 0;
    pt_n[g]   = 0;
    cap_n[g]  = 0;
    done_n[g] = 0;
  endtask

  task automatic go(input int g, output int s);
    step();
    start[g] = 1'b1;
    s = ncyc;
    step();
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget);
    int k = 0;
    while (done_n[g] == 0 && k < budget) begin
      step();
      k++;
    end
    chk("done_count", done_n[g], 1);
  endtask

  initial begin
    int s, k;
    rst_n = 1'b0;
    key   = '0;
    seed  = '0;
    for (int g = 0; g < NI; g++) begin
      start[g]     = 1'b0;
      abort[g]     = 1'b0;
      man_valid[g] = 1'b0;
      core_on[g]   = 1'b1;
      dout[g]      = '0;
      clr(g);
    end
    repeat (3) step();
    chk("rst_ctrl", {en[0], busy[0], done[0], capv[0], terr[0]}, 0);
    chk("rst_din", din[0], 0);
    chk("rst_kin", kin[0], 0);
    chk("rst_capd", capd[0], 0);
    chk("rst_tidx", tidx[0], 0);
    rst_n = 1'b1;
    step();

    key  = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
    seed = 128'h00000086_00000000_00000000_00000000;
    clr(0);
    go(0, s);
    chk("m0_busy", busy[0], 1);
    wait_done(0, 400);
    chk("m0_done_cyc", done_at[0] - s, 135);
    chk("m0_busy_done", busy[0], 0);
    chk("m0_runs", run_n[0], 2);
    chk("m0_run0", en_runs[0][0], 51);
    chk("m0_run1", en_runs[0][1], 51);
    chk("m0_gap", gap_log[0][0], 16);
    chk("m0_gap_din", gap_din[0], ~seed);
    chk("m0_pt0", pt_log[0][0], seed);
    chk("m0_pt1", pt_log[0][1], seed);
    chk("m0_key", kin[0], key);
    chk("m0_caps", cap_n[0], 2);
    chk("m0_tidx", tidx[0], 1);
    chk("m0_terr", terr[0], 0);

    clr(0);
    go(0, s);
    k = 0;
    while (!(en[0] === 1'b1 && tidx[0] == 16'd1) && k < 300) begin
      step();
      k++;
    end
    chk("ab_reach", {en[0], tidx[0]}, {1'b1, 16'd1});
    abort[0] = 1'b1;
    step();
    abort[0] = 1'b0;
    chk("ab_en", en[0], 0);
    chk("ab_busy", busy[0], 0);
    repeat (100) step();
    chk("ab_nodone", done_n[0], 0);
    chk("ab_caps", cap_n[0], 1);
    clr(0);
    go(0, s);
    chk("rs_tidx", tidx[0], 0);
    chk("rs_busy", busy[0], 1);
    wait_done(0, 400);
    chk("rs_done_cyc", done_at[0] - s, 135);
    chk("rs_caps", cap_n[0], 2);

    step();
    start[1] = 1'b1;
    abort[1] = 1'b1;
    step();
    start[1] = 1'b0;
    abort[1] = 1'b0;
    chk("sa_busy", busy[1], 0);
    step();
    chk("sa_busy2", busy[1], 0);

    seed = 128'h1;
    clr(1);
    go(1, s);
    wait_done(1, 400);
    chk("m1_pt0", pt_log[1][0], 128'h3);
    chk("m1_pt1", pt_log[1][1], 128'h6);
    chk("m1_caps", cap_n[1], 2);

    seed = '0;
    clr(1);
    go(1, s);
    wait_done(1, 400);
    chk("m1z_pt0", pt_log[1][0], 128'h3);
    chk("m1z_pt1", pt_log[1][1], 128'h6);

    seed = 128'h1;
    clr(2);
    go(2, s);
    wait_done(2, 600);
    chk("m2_done_cyc", done_at[2] - s, 269);
    chk("m2_pt0", pt_log[2][0], 128'h1);
    chk("m2_pt1", pt_log[2][1], 128'h3);
    chk("m2_pt2", pt_log[2][2], 128'h1);
    chk("m2_pt3", pt_log[2][3], 128'h6);
    chk("m2_caps", cap_n[2], 4);
    chk("m2_tidx", tidx[2], 3);

    core_on[3] = 1'b0;
    seed = 128'h55;
    clr(3);
    go(3, s);
    k = 0;
    while (tidx[3] != 16'd1 && k < 300) begin
      step();
      k++;
    end
    chk("to_err_t1", terr[3], 1);
    wait_done(3, 400);
    chk("to_err_end", terr[3], 1);
    chk("to_caps", cap_n[3], 0);
    chk("to_runs", run_n[3], 2);

    core_on[0] = 1'b0;
    clr(0);
    go(0, s);
    k = 0;
    while (run_n[0] == 0 && k < 200) begin
      step();
      k++;
    end
    repeat (2) step();
    chk("rw_busy", busy[0], 1);
    rst_n = 1'b0;
    #1;
    chk("rw_ctrl", {en[0], busy[0], done[0], capv[0], terr[0]}, 0);
    chk("rw_din", din[0], 0);
    chk("rw_kin", kin[0], 0);
    chk("rw_capd", capd[0], 0);
    chk("rw_tidx", tidx[0], 0);
    step();
    rst_n = 1'b1;
    man_valid[0] = 1'b1;
    step();
    man_valid[0] = 1'b0;
    repeat (5) step();
    chk("rw_nocap", cap_n[0], 0);
    chk("rw_idle", busy[0], 0);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_trace_sequencer.md
AES_TRACE_SEQUENCER -- requirements
Module: aes_trace_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 128: width of the plaintext, key and ciphertext buses.
REQ-002 SHALL have parameter N_TRACES, default 16: encryptions per sequence (1..65535).
REQ-003 SHALL have parameter EN_CYCLES, default 51: cycles AES_en is held high per trace (>=1).
REQ-004 SHALL have parameter GAP_CYCLES, default 15: idle cycles between traces (>=1).
REQ-005 SHALL have parameter TIMEOUT, default 256: maximum cycles spent in WAIT for AES_data_out_valid.
REQ-006 SHALL have parameter MODE, default 1: 0 = fixed plaintext, 1 = LFSR random, 2 = alternating fixed/random.
REQ-007 SHALL have ports:
- AES_clk  in  1  clock; one clock domain, all logic on the rising edge.
- AES_rst_n  in  1  asynchronous, active-low reset.
- seq_start  in  1  start pulse; ignored while seq_busy=1.
- seq_abort  in  1  abort request.
- seq_key  in  DATA_W  key, sampled at start.
- seq_seed  in  DATA_W  fixed plaintext and LFSR seed, sampled at start.
- AES_en  out  1  core enable.
- AES_data_in  out  DATA_W  plaintext to the core.
- AES_key_in  out  DATA_W  key to the core.
- AES_data_out  in  DATA_W  core ciphertext.
- AES_data_out_valid  in  1  core output strobe.
- seq_busy  out  1  high while the sequence runs.
- seq_done  out  1  one-cycle pulse at sequence end.
- trace_idx  out  16  index of the current trace.
- cap_data  out  DATA_W  captured ciphertext.
- cap_valid  out  1  one-cycle capture strobe.
- timeout_err  out  1  sticky WAIT-timeout flag.

Function
REQ-008 SHALL implement FSM states IDLE, LOAD, RUN, WAIT, GAP, DONE.
REQ-009 IDLE->LOAD SHALL occur on seq_start: register seq_key and seq_seed, clear trace_idx and timeout_err, and set seq_busy next cycle.
REQ-010 LOAD SHALL last 1 cycle: select the plaintext per MODE, drive AES_data_in and AES_key_in, go to RUN.
REQ-011 Plaintext selection SHALL be:
- MODE 0: seed on every trace.
- MODE 1: LFSR state.
- MODE 2: seed on even trace_idx, LFSR on odd trace_idx.
REQ-012 LFSR SHALL start at the seed and step once per LOAD in which it is used, before use: next = {cur[DATA_W-2:0], cur[DATA_W-1]^cur[6]^cur[1]^cur[0]}.
REQ-013 An all-zero seed in MODE 1 or 2 SHALL be replaced by 1.
REQ-014 RUN SHALL hold AES_en=1 for exactly EN_CYCLES cycles with AES_data_in and AES_key_in stable.
REQ-015 At the end of RUN, the FSM SHALL go to GAP if a capture already occurred for this trace, else to WAIT.
REQ-016 A capture SHALL occur on the first AES_data_out_valid seen in RUN or WAIT per trace: cap_data<=AES_data_out and cap_valid=1 for one cycle.
REQ-017 Later valid pulses in the same trace, and valid pulses in IDLE, GAP or DONE, SHALL be ignored.
REQ-018 WAIT SHALL go to GAP on capture; after TIMEOUT cycles without capture it SHALL set timeout_err=1 and go to GAP.
REQ-019 GAP SHALL last GAP_CYCLES cycles with AES_en=0 and AES_data_in = bitwise inverse of the last plaintext, keeping the bus toggling.
REQ-020 At the end of GAP, the FSM SHALL go to LOAD with trace_idx+1 if trace_idx < N_TRACES-1, else to DONE.
REQ-021 DONE SHALL pulse seq_done for 1 cycle, clear seq_busy, and go to IDLE.
REQ-022 seq_abort SHALL take priority over every other event: from any state except IDLE, the next state is IDLE with AES_en=0, seq_busy=0, and no seq_done.
REQ-023 seq_start and seq_abort asserted in the same cycle in IDLE SHALL result in no start.
REQ-024 The trace_idx counter SHALL saturate and never wrap.

Reset
REQ-025 AES_rst_n=0 SHALL asynchronously force state IDLE and set AES_en, AES_data_in, AES_key_in, cap_data, cap_valid, seq_busy, seq_done, trace_idx, timeout_err and the LFSR to 0.
REQ-026 Reset asserted mid-sequence SHALL behave identically to reset from idle, and no capture SHALL be emitted after release.

Verification
REQ-027 Test MODE 0, N_TRACES=2, key aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc, seed 00000086_0..0, core model giving valid at RUN cycle 40 -> AES_en high 51 cycles twice, 15-cycle gaps, 2 cap_valid pulses, seq_done at cycle 1+51+15+1+51+15+1 after start.
REQ-028 Test MODE 1, seed 1 -> trace 0 plaintext 0x...03, trace 1 plaintext 0x...06.
REQ-029 Test MODE 2, seed 1 -> plaintexts 0x1, 0x3, 0x1, 0x6 for traces 0-3.
REQ-030 Test a core that never asserts valid, TIMEOUT=4 -> timeout_err=1 after the first trace, sequence still completes, 0 cap_valid pulses.
REQ-031 Test seq_abort during RUN of trace 1 -> AES_en=0 the next cycle, no seq_done; a subsequent seq_start restarts at trace_idx 0.
REQ-032 Test AES_rst_n low for 1 cycle mid-WAIT -> all outputs 0 immediately; a valid arriving after release produces no cap_valid.
